// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encoding matches the 2-bit op port: bit 1 selects divide, bit 0 selects signed.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } mdu_state_t;

    function automatic logic op_is_signed(input mdu_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_t o);
        return (o == DIVU) || (o == DIV);
    endfunction

endpackage

// File: rtl/twos_magnitude.sv
// Conditional two's-complement negate. With neg = sign bit it yields |value|,
// with neg = a result sign flag it restores the signed result.
module twos_magnitude #(
    parameter int w = 32
) (
    input  logic [w-1:0] value,
    input  logic         neg,
    output logic [w-1:0] result
);

    assign result = neg ? (~value + {{(w-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per cycle.
// The last step's result is sign-corrected on its way into hi/lo, so done and the new hi/lo share the FINISH cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int n = MDU_WIDTH
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] srcA,
    input  logic [n-1:0] srcB,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo,
    output logic         divByZero
);

    localparam int cw = $clog2(n) + 1;

    mdu_state_t     state;
    logic [cw-1:0]  cnt;
    logic [2*n-1:0] acc;     // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [n-1:0]   opnd;    // multiplicand magnitude or divisor magnitude
    logic           is_div_q;
    logic           neg_q;   // negate product or quotient
    logic           neg_r;   // negate remainder
    logic           dbz_q;

    // Accept-side decode and operand magnitudes.
    mdu_op_t      op_in;
    logic         in_signed;
    logic         in_div;
    logic [n-1:0] abs_a;
    logic [n-1:0] abs_b;

    assign op_in     = mdu_op_t'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);

    twos_magnitude #(.w(n)) u_mag_a (
        .value  (srcA),
        .neg    (in_signed & srcA[n-1]),
        .result (abs_a)
    );

    twos_magnitude #(.w(n)) u_mag_b (
        .value  (srcB),
        .neg    (in_signed & srcB[n-1]),
        .result (abs_b)
    );

    // One iteration of either algorithm.
    logic [n:0]     mul_sum;
    logic [n:0]     div_shift;
    logic [n:0]     div_diff;
    logic [2*n-1:0] acc_next;

    assign mul_sum   = {1'b0, acc[2*n-1:n]} + (acc[0] ? {1'b0, opnd} : {(n+1){1'b0}});
    assign div_shift = {acc[2*n-1:n], acc[n-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        acc_next = {mul_sum, acc[n-1:1]};
        if (is_div_q) begin
            if (!div_diff[n])
                acc_next = {div_diff[n-1:0], acc[n-2:0], 1'b1};
            else
                acc_next = {div_shift[n-1:0], acc[n-2:0], 1'b0};
        end
    end

    // Sign correction of the final step's value.
    logic [2*n-1:0] prod_fix;
    logic [n-1:0]   quo_fix;
    logic [n-1:0]   rem_fix;
    logic [n-1:0]   res_hi;
    logic [n-1:0]   res_lo;

    twos_magnitude #(.w(2*n)) u_fix_prod (
        .value  (acc_next),
        .neg    (neg_q),
        .result (prod_fix)
    );

    twos_magnitude #(.w(n)) u_fix_quo (
        .value  (acc_next[n-1:0]),
        .neg    (neg_q),
        .result (quo_fix)
    );

    twos_magnitude #(.w(n)) u_fix_rem (
        .value  (acc_next[2*n-1:n]),
        .neg    (neg_r),
        .result (rem_fix)
    );

    // A zero divisor leaves the dividend magnitude in the remainder, which the
    // dividend-sign correction turns back into srcA; only the quotient is forced.
    assign res_hi = is_div_q ? rem_fix : prod_fix[2*n-1:n];
    assign res_lo = is_div_q ? (dbz_q ? {n{1'b1}} : quo_fix) : prod_fix[n-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            // NOTE: datapath registers are reset too, so an aborted op leaves no stale state behind.
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dbz_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        cnt      <= cw'(n);
                        is_div_q <= in_div;
                        neg_q    <= in_signed & (srcA[n-1] ^ srcB[n-1]);
                        neg_r    <= in_signed & srcA[n-1];
                        dbz_q    <= in_div & (srcB == '0);
                        opnd     <= in_div ? abs_b : abs_a;
                        acc      <= {{n{1'b0}}, (in_div ? abs_a : abs_b)};
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt - cw'(1);
                    if (cnt == cw'(1)) begin
                        state     <= FINISH;
                        hi        <= res_hi;
                        lo        <= res_lo;
                        divByZero <= dbz_q;
                        done      <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and randomized ops against a
// 64-bit arithmetic reference, plus hold, back-to-back and reset-abort scenarios.
module tb_mul_div_unit;

    localparam int n = 32;

    logic         clk = 1'b0;
    logic         nReset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [n-1:0] srcA = '0;
    logic [n-1:0] srcB = '0;
    logic         busy;
    logic         done;
    logic [n-1:0] hi;
    logic [n-1:0] lo;
    logic         divByZero;

    int n_pass  = 0;
    int n_total = 0;

    mul_div_unit #(.n(n)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .start     (start),
        .op        (op),
        .srcA      (srcA),
        .srcB      (srcB),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic with SV truncating division semantics.
    function automatic void ref_model(input logic [1:0] o, input logic [n-1:0] a, input logic [n-1:0] b,
                                      output logic [n-1:0] rh, output logic [n-1:0] rl, output logic rz);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = $signed(a);
        sb = $signed(b);
        rz = 1'b0;
        case (o)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = sa * sb;
            default: begin
                if (b == '0) begin
                    rz = 1'b1;
                    p  = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    p = {a % b, a / b};
                end else begin
                    p[63:32] = 32'(sa % sb);
                    p[31:0]  = 32'(sa / sb);
                end
            end
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    function automatic logic [n-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Drives one request, scrambles inputs after accept, and records what the DUT did.
    task automatic issue(input logic [1:0] o, input logic [n-1:0] a, input logic [n-1:0] b,
                         output logic [n-1:0] rh, output logic [n-1:0] rl, output logic rz,
                         output int lat, output int timing_err);
        logic exp_busy;
        lat = -1;
        timing_err = 0;
        rh = 'x;
        rl = 'x;
        rz = 1'bx;
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); srcA = 32'($urandom); srcB = 32'($urandom);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            exp_busy = (k <= n + 1);
            if (busy !== exp_busy) timing_err++;
            if (done === 1'b1) begin
                if (lat < 0) begin
                    lat = k; rh = hi; rl = lo; rz = divByZero;
                end else begin
                    timing_err++;
                end
            end
        end
    endtask

    task automatic exercise_op(input string name, input logic [1:0] o, input logic [n-1:0] a, input logic [n-1:0] b);
        logic [n-1:0] gh, gl, eh, el;
        logic         gz, ez;
        int           lat, terr;
        ref_model(o, a, b, eh, el, ez);
        issue(o, a, b, gh, gl, gz, lat, terr);
        n_total++; if (lat !== n + 1) $display("FAIL %s latency got %0d want %0d", name, lat, n + 1); else n_pass++;
        n_total++; if (terr !== 0) $display("FAIL %s busy/done timing errors got %0d want 0", name, terr); else n_pass++;
        n_total++; if (gh !== eh) $display("FAIL %s op=%0d a=%h b=%h hi got %h want %h", name, o, a, b, gh, eh); else n_pass++;
        n_total++; if (gl !== el) $display("FAIL %s op=%0d a=%h b=%h lo got %h want %h", name, o, a, b, gl, el); else n_pass++;
        n_total++; if (gz !== ez) $display("FAIL %s op=%0d a=%h b=%h divByZero got %b want %b", name, o, a, b, gz, ez); else n_pass++;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset done got %b want 0", done); else n_pass++;
        n_total++; if (hi !== '0) $display("FAIL reset hi got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== '0) $display("FAIL reset lo got %h want 0", lo); else n_pass++;
        n_total++; if (divByZero !== 1'b0) $display("FAIL reset divByZero got %b want 0", divByZero); else n_pass++;
        nReset = 1'b1;
    endtask

    task automatic test_directed();
        exercise_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exercise_op("mult_neg", 2'b01, -32'd3, 32'd7);
        exercise_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000);
        exercise_op("divu_small", 2'b10, 32'd100, 32'd7);
        exercise_op("div_neg", 2'b11, -32'd7, 32'd2);
        exercise_op("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        exercise_op("div_by_zero", 2'b11, 32'd5, 32'd0);
        exercise_op("dbz_cleared", 2'b10, 32'd9, 32'd3);
        exercise_op("div_neg_by_zero", 2'b11, -32'd7, 32'd0);
        exercise_op("divu_by_zero", 2'b10, 32'h8000_0001, 32'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            exercise_op("random", 2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    endtask

    task automatic test_hold();
        logic [n-1:0] eh, el;
        logic         ez;
        int           bad;
        exercise_op("hold_setup", 2'b11, -32'd100, 32'd7);
        ref_model(2'b11, -32'd100, 32'd7, eh, el, ez);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            op = 2'($urandom); srcA = 32'($urandom); srcB = 32'($urandom);
            if (hi !== eh || lo !== el || divByZero !== ez || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL hold outputs changed while idle in %0d cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [n-1:0] a2, b2, eh1, el1, eh2, el2, gh1, gl1, gh2, gl2;
        logic [1:0]   o2;
        logic         ez1, ez2, gz2, exp_busy;
        int           lat1, lat2, terr, pulses;
        o2 = 2'b11; a2 = -32'd1000; b2 = 32'd33;
        ref_model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh1, el1, ez1);
        ref_model(o2, a2, b2, eh2, el2, ez2);
        lat1 = -1; lat2 = -1; terr = 0; pulses = 0;
        gh1 = 'x; gl1 = 'x; gh2 = 'x; gl2 = 'x; gz2 = 1'bx;
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        op = o2; srcA = a2; srcB = b2;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 35) start = 1'b0;
            exp_busy = (k <= 33) || (k >= 35 && k <= 67);
            if (busy !== exp_busy) terr++;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin lat1 = k; gh1 = hi; gl1 = lo; end
                if (pulses == 2) begin lat2 = k; gh2 = hi; gl2 = lo; gz2 = divByZero; end
            end
        end
        n_total++; if (lat1 !== 33) $display("FAIL b2b first done cycle got %0d want 33", lat1); else n_pass++;
        n_total++; if (lat2 !== 67) $display("FAIL b2b second done cycle got %0d want 67", lat2); else n_pass++;
        n_total++; if (pulses !== 2) $display("FAIL b2b done pulses got %0d want 2", pulses); else n_pass++;
        n_total++; if (terr !== 0) $display("FAIL b2b busy errors got %0d want 0", terr); else n_pass++;
        n_total++; if ({gh1, gl1} !== {eh1, el1}) $display("FAIL b2b first result got %h_%h want %h_%h", gh1, gl1, eh1, el1); else n_pass++;
        n_total++; if ({gh2, gl2} !== {eh2, el2}) $display("FAIL b2b second result got %h_%h want %h_%h", gh2, gl2, eh2, el2); else n_pass++;
        n_total++; if (gz2 !== ez2) $display("FAIL b2b second divByZero got %b want %b", gz2, ez2); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'h1234_5678; srcB = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (k == 10) nReset = 1'b0;
        end
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL abort busy got %b want 0", busy); else n_pass++;
        n_total++; if (hi !== '0) $display("FAIL abort hi got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== '0) $display("FAIL abort lo got %h want 0", lo); else n_pass++;
        nReset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL abort done pulses got %0d want 0", pulses); else n_pass++;
        exercise_op("after_abort", 2'b01, 32'h1234_5678, -32'd2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the execute stage, directly upstream of the execute-result 2:1 multiplexer (`n` = 32). It accepts MULT/MULTU/DIV/DIVU requests, computes them over multiple cycles with one shift-add or shift-subtract step per cycle, and holds the results in HI/LO registers. The result mux then selects between the ALU result and HI/LO. Control stalls the pipeline while `busy` is high.

## Interface
- `n`, 32, operand/result width (≥ 4, even)
- `clk`  in  1  single clock; all state updates on rising edge
- `nReset`  in  1  synchronous, active-low reset
- `start`  in  1  request strobe; sampled only when `busy`=0
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `srcA`  in  n  multiplicand / dividend
- `srcB`  in  n  multiplier / divisor
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; `hi`/`lo` updated this cycle
- `hi`  out  n  product upper half / remainder
- `lo`  out  n  product lower half / quotient
- `divByZero`  out  1  last completed op was DIV/DIVU with `srcB`=0

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE, `start`=1:
  - latch `op`;
  - latch |srcA| and |srcB| (two's-complement magnitude for signed ops, raw for unsigned);
  - latch the result sign flags;
  - load step counter = `n`;
  - go to RUN.
- RUN: one iteration per cycle; decrement counter; go to FINISH when the counter reaches 0 (after exactly `n` iterations).
  - Multiply: unsigned shift-add into a 2n-bit accumulator.
  - Divide: restoring shift-subtract; quotient and remainder are n bits each.
- FINISH:
  - apply sign correction;
  - write `hi`/`lo`/`divByZero`;
  - `done`=1;
  - go to IDLE.
- Sign rules:
  - product is negated if operand signs differ;
  - quotient is negated if signs differ;
  - remainder takes the sign of the dividend.
  - For unsigned ops all sign flags are 0.
- Product: full 2n-bit result, `hi` = [2n-1:n], `lo` = [n-1:0]; no truncation or overflow flag.
- Divide by zero (`srcB`=0, DIV or DIVU):
  - `lo` = all ones, `hi` = `srcA` unmodified, `divByZero`=1;
  - latency is unchanged.
- Signed overflow (DIV −2^(n−1) / −1): `lo` = 0x80000000, `hi` = 0. This falls out of the magnitude algorithm and needs no special case.
- `divByZero` is cleared on any non-divide-by-zero completion.
- `hi`, `lo` and `divByZero` hold between completions.
- `start` while `busy`=1: ignored, no side effects; operands are not re-latched.
- `srcA`/`srcB`/`op` may change after the accept cycle without effect.

## Timing
- Reset (`nReset`=0 at an edge):
  - state → IDLE;
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, `divByZero`=0;
  - counter and accumulators are cleared.
- Reset mid-RUN or mid-FINISH aborts the operation: no `done`, and `hi`/`lo` are cleared.
- Accept at edge 0 (cycle 0 has `start`=1, `busy`=0).
- `busy`=1 in cycles 1..n+1.
- `done`=1 and new `hi`/`lo` visible in cycle n+1 (cycle 33 for `n`=32).
- Latency is identical for all ops, including divide-by-zero.
- `busy` falls in cycle n+2. The earliest next accept is a `start` sampled in cycle n+2.
- `start` sampled in the `done` cycle is ignored, because `busy`=1 then.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mdu_pkg` holds:
  - `mdu_op_t` enum (MULTU, MULT, DIVU, DIV);
  - `mdu_state_t` enum (IDLE, RUN, FINISH);
  - default width constant 32.
- One sub-module is natural: `twos_magnitude`, a combinational conditional negate/absolute value of width `n`.
  - Instantiate it for operand magnitude on accept.
  - Instantiate it for result sign correction in FINISH.
- FSM, counter and datapath live in `mul_div_unit`.

## Test plan
- MULTU `srcA`=0xFFFFFFFF, `srcB`=0xFFFFFFFF → `done` in cycle 33 with `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy`=1 in cycles 1..33.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIVU 100 / 7 → `lo`=14, `hi`=2. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV 5 / 0 → `divByZero`=1, `lo`=0xFFFFFFFF, `hi`=5 in cycle 33. A following DIVU 9 / 3 → `divByZero`=0, `lo`=3, `hi`=0.
- `start` held high with new operands through the whole run → the second request is accepted only at cycle 34 and completes at cycle 67. The first result is unaffected.
- `nReset`=0 in cycle 10 of a MULTU → in the next cycle `busy`=0 and `hi`=`lo`=0. No `done` pulse ever occurs for the aborted op.
